// File: rtl/divider_arbiter_if.sv
// Requester-side bus of the divider arbiter: packed per-requester operands in,
// one-hot accept and one-hot result strobe out, shared result data.
interface divider_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
  logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [NUM_REQ-1:0]       resp_valid_out;
  logic [WIDTH-1:0]         resp_quotient_out;
  logic [WIDTH-1:0]         resp_remainder_out;
  logic                     resp_error_out;

  modport master (
    output req_valid_in, req_dividend_in, req_divisor_in,
    input  req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out, resp_error_out
  );

  modport slave (
    input  req_valid_in, req_dividend_in, req_divisor_in,
    output req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out, resp_error_out
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one sequential divider between NUM_REQ requesters, with a
// zero-divisor short-circuit and a watchdog that answers with an error if the divider stalls.
module divider_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  divider_arbiter_if.slave   req_bus,
  output logic [WIDTH-1:0]   div_dividend_out,
  output logic [WIDTH-1:0]   div_divisor_out,
  output logic               div_valid_out,
  input  logic [WIDTH-1:0]   div_quotient_in,
  input  logic [WIDTH-1:0]   div_remainder_in,
  input  logic               div_valid_in,
  input  logic               div_error_in,
  input  logic               div_busy_in,
  output logic               busy_out
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    rr_ptr_q;
  logic [IdxW-1:0]    grant_q;
  logic [TimerW-1:0]  timer_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               error_q;
  logic               div_valid_q;
  logic [NUM_REQ-1:0] resp_valid_q;

  logic               grant_found;
  logic [IdxW-1:0]    grant_idx;
  logic               accept;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic [NUM_REQ-1:0] grant_idx_oh;
  logic [NUM_REQ-1:0] grant_q_oh;
  logic [IdxW-1:0]    rr_next;
  logic               div_done;
  logic               timed_out;

  // First requesting index at or after rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned j;
    logic [IdxW-1:0] jj;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    jj          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IdxW'(j);
      if (!grant_found && req_bus.req_valid_in[jj]) begin
        grant_found = 1'b1;
        grant_idx   = jj;
      end
    end
  end

  // A busy divider in IDLE may still be finishing an abandoned job; do not start another.
  assign accept       = (state_q == StIdle) && !div_busy_in && grant_found;
  assign sel_dividend = req_bus.req_dividend_in[32'(grant_idx)*WIDTH +: WIDTH];
  assign sel_divisor  = req_bus.req_divisor_in[32'(grant_idx)*WIDTH +: WIDTH];
  assign grant_idx_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
  assign grant_q_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign rr_next      = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign div_done     = div_valid_in && !div_busy_in;
  assign timed_out    = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_bus.req_ready_out = '0;
    if (accept) req_bus.req_ready_out = grant_idx_oh;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      timer_q      <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      error_q      <= 1'b0;
      div_valid_q  <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      div_valid_q  <= 1'b0;
      resp_valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            grant_q    <= grant_idx;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            if (sel_divisor == '0) begin
              quotient_q   <= '0;
              remainder_q  <= '0;
              error_q      <= 1'b1;
              resp_valid_q <= grant_idx_oh;
              state_q      <= StRespond;
            end else begin
              div_valid_q <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (div_done) begin
            quotient_q   <= div_quotient_in;
            remainder_q  <= div_remainder_in;
            error_q      <= div_error_in;
            resp_valid_q <= grant_q_oh;
            state_q      <= StRespond;
          end else if (timed_out) begin
            quotient_q   <= '0;
            remainder_q  <= '0;
            error_q      <= 1'b1;
            resp_valid_q <= grant_q_oh;
            state_q      <= StRespond;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRespond: begin
          rr_ptr_q <= rr_next;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_bus.resp_valid_out     = resp_valid_q;
  assign req_bus.resp_quotient_out  = quotient_q;
  assign req_bus.resp_remainder_out = remainder_q;
  assign req_bus.resp_error_out     = error_q;
  assign div_dividend_out           = dividend_q;
  assign div_divisor_out            = divisor_q;
  assign div_valid_out              = div_valid_q;
  assign busy_out                   = (state_q != StIdle);

endmodule
